// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcode/funct
// values, ALU operations and datapath mux select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU decoder: turns the FSM's coarse ALUOp (add / sub / use funct) into the
// 3-bit ALUControl seen by the shared ALU.
module mips_alu_dec
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           i_alu_op,
  input  logic [FUNCT_W-1:0]   i_funct,
  output logic [ALUCTRL_W-1:0] o_alu_ctrl
);

  // only add and sub exist; anything unexpected falls back to add
  always_comb begin
    o_alu_ctrl = ALUCTRL_W'(ALU_ADD);
    case (i_alu_op)
      ALUOP_ADD: o_alu_ctrl = ALUCTRL_W'(ALU_ADD);
      ALUOP_SUB: o_alu_ctrl = ALUCTRL_W'(ALU_SUB);
      ALUOP_FUNCT: begin
        if (i_funct == F_SUB) o_alu_ctrl = ALUCTRL_W'(ALU_SUB);
        else                  o_alu_ctrl = ALUCTRL_W'(ALU_ADD);
      end
      default: o_alu_ctrl = ALUCTRL_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore main controller for the multicycle MIPS datapath: one state register,
// combinational next-state and control outputs, write enables gated by reset.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_W-1:0]      Op,
  input  logic [FUNCT_W-1:0]   Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic                 illegal_instr,
  output logic [3:0]           state_dbg
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [1:0] w_alu_op;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_illegal;

  mips_alu_dec #(
    .FUNCT_W  (FUNCT_W),
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_dec (
    .i_alu_op  (w_alu_op),
    .i_funct   (Funct),
    .o_alu_ctrl(ALUControl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = FETCH;
    w_alu_op   = ALUOP_ADD;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    PCSrc      = PC_ALU;
    case (r_state)
      FETCH: begin
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = DECODE;
        end else begin
          w_next = FETCH;
        end
      end
      DECODE: begin
        // branch target is formed here so BRANCH only has to compare
        ALUSrcB = SRCB_IMM_SH;
        case (Op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE: begin
            if (Funct == F_ADD || Funct == F_SUB) begin
              w_next = EXECUTE;
            end else begin
              w_next    = FETCH;
              w_illegal = 1'b1;
            end
          end
          OP_BEQ:  w_next = BRANCH;
          OP_ADDI: w_next = ADDIEX;
          OP_J:    w_next = JUMP;
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (Op == OP_SW) w_next = MEMWRITE;
        else             w_next = MEMREAD;
      end
      MEMREAD: begin
        IorD   = 1'b1;
        w_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = FETCH;
      end
      MEMWRITE: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        ALUSrcA  = 1'b1;
        w_alu_op = ALUOP_FUNCT;
        w_next   = ALUWB;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
        w_next     = FETCH;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        w_alu_op = ALUOP_SUB;
        PCSrc    = PC_ALUOUT;
        w_branch = 1'b1;
        w_next   = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = ADDIWB;
      end
      ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = FETCH;
      end
      JUMP: begin
        PCSrc     = PC_JUMP;
        w_pcwrite = 1'b1;
        w_next    = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  // reset kills every enable combinationally so an aborted instruction writes nothing
  assign MemWrite      = w_memwrite & rst_n;
  assign IRWrite       = w_irwrite & rst_n;
  assign RegWrite      = w_regwrite & rst_n;
  assign PCEn          = (w_pcwrite | (w_branch & Zero)) & rst_n;
  assign illegal_instr = w_illegal & rst_n;
  assign state_dbg     = r_state;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style main controller for the multicycle MIPS datapath. It sequences the shared ALU for PC increment, branch-target computation, address generation, R-type execution and branch compare. It drives the mux selects and write enables around the ALU, register file, IR, PC and memory. ALU operations are restricted to add (3'b010) and sub (3'b110).

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
ALUCTRL_W, 3, ALUControl width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
Op  in  OP_W  IR[31:26], stable outside FETCH
Funct  in  FUNCT_W  IR[5:0]
Zero  in  1  ALU result == 0
mem_ready  in  1  memory access completes this cycle
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register load
RegDst  out  1  destination register select: 0 = rt, 1 = rd
MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = Data
RegWrite  out  1  register file write enable
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
ALUControl  out  ALUCTRL_W  ALU operation
PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
PCEn  out  1  PC load: PCWrite | (Branch & Zero)
illegal_instr  out  1  one-cycle pulse in DECODE on an unsupported instruction
state_dbg  out  4  current state encoding

Behaviour:
- Single state register; next-state logic and outputs are combinational from state, plus Op/Funct/Zero/mem_ready where listed below.
- Reset: rst_n low forces state to FETCH asynchronously. While rst_n is low, MemWrite, IRWrite, RegWrite, PCEn and illegal_instr are forced to 0. Other outputs take their FETCH values.
- Output defaults in every state: all 1-bit outputs 0, ALUSrcB = 00, PCSrc = 00, ALUControl = 010.
- FETCH: ALUSrcB = 01, add. If mem_ready, assert IRWrite = 1 and PCWrite = 1, then go to DECODE. Otherwise hold FETCH with IRWrite and PCEn at 0.
- DECODE: ALUSrcB = 11, add (branch target computed into ALUOut). Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE if Funct is 100000 or 100010; otherwise FETCH with illegal_instr = 1
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other Op -> FETCH with illegal_instr = 1
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, add. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IorD = 1. Hold until mem_ready, then go to MEMWB.
- MEMWB: MemtoReg = 1, RegWrite = 1, RegDst = 0, then FETCH.
- MEMWRITE: IorD = 1, MemWrite = 1 held every cycle until mem_ready, then FETCH.
- EXECUTE: ALUSrcA = 1, ALUSrcB = 00, ALUControl = 010 for funct 100000, 110 for funct 100010. Then ALUWB.
- ALUWB: RegDst = 1, RegWrite = 1, then FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUControl = 110, PCSrc = 01, Branch = 1, so PCEn = Zero. Then FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, add. Then ADDIWB.
- ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1. Then FETCH.
- JUMP: PCSrc = 10, PCWrite = 1. Then FETCH.
- Cycle counts with mem_ready held at 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal instruction: 2 cycles
  - Each cycle of mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Unreachable state encodings go to FETCH on the next clock, with all outputs at their defaults.
- Reset asserted mid-instruction aborts it. Enables drop in the same cycle; there is no partial writeback.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants: F_ADD, F_SUB
  - ALU constants: ALU_ADD = 3'b010, ALU_SUB = 3'b110
  - ALUSrcB and PCSrc encodings
- One sub-module, mips_alu_dec: maps a 2-bit ALUOp (00 add, 01 sub, 10 funct) plus Funct to ALUControl. It is instantiated by the FSM.

Test Plan:
1. Hold rst_n = 0 with mem_ready = 1 -> MemWrite/IRWrite/RegWrite/PCEn = 0 and state_dbg = FETCH. After release, first edge: IRWrite = 1, PCEn = 1, ALUSrcB = 01, ALUControl = 010.
2. Op = 000000, Funct = 100010 -> FETCH, DECODE, EXECUTE (ALUControl = 110, ALUSrcB = 00), ALUWB (RegWrite = 1, RegDst = 1), FETCH: 4 cycles, illegal_instr = 0.
3. beq (Op = 000100) with Zero = 1 -> BRANCH shows ALUControl = 110, PCSrc = 01, PCEn = 1. Repeat with Zero = 0 -> PCEn = 0, back to FETCH.
4. lw with mem_ready low for 3 cycles in MEMREAD -> IorD = 1 held, no RegWrite. Then MEMWB with MemtoReg = 1, RegWrite = 1: 8 cycles total.
5. sw with mem_ready low for 2 cycles in FETCH -> IRWrite = 0 and PCEn = 0 while stalled. MEMWRITE asserts MemWrite = 1 with IorD = 1. Then addi gives ALUSrcB = 10 in ADDIEX and RegWrite = 1, RegDst = 0 in ADDIWB.
6. Op = 111111, then Op = 0 with Funct = 100100 -> illegal_instr pulses once in DECODE, FETCH follows, no RegWrite/MemWrite. Drop rst_n mid-MEMWRITE -> MemWrite falls immediately (no clock edge) and state_dbg = FETCH.
